// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 LCD sequencer: power-up init, then copies two 128-bit row images into DDRAM.
// Optional LCD_AUTO_REFRESH_EN: refresh automatically whenever the rows differ from the last snapshot.
//
// state     | meaning
// POWER     | power-on wait of T_POWER cycles
// INIT      | sending 0x38, 0x0C, 0x06, 0x01
// IDLE      | waiting for update / pending / auto request
// REFRESH   | sending 0x80, row1[0..15], 0xC0, row2[0..15]
// phase (INIT/REFRESH): SETUP -> PULSE (en high) -> SETTLE
module lcd_refresh_ctrl #(
   parameter int T_POWER = 400000,
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 10,
   parameter int T_WAIT  = 500,
   parameter int T_CLEAR = 20000
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic [127:0] row1,
   input  logic [127:0] row2,
   input  logic         update,
   output logic         busy,
   output logic         init_done,
   output logic         lcd_en,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic [7:0]   lcd_data
);

   localparam int M1    = (T_POWER > T_SETUP) ? T_POWER : T_SETUP;
   localparam int M2    = (M1 > T_PULSE) ? M1 : T_PULSE;
   localparam int M3    = (M2 > T_WAIT) ? M2 : T_WAIT;
   localparam int T_MAX = (M3 > T_CLEAR) ? M3 : T_CLEAR;
   localparam int CW    = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] L_POWER = CW'(T_POWER - 1);
   localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] L_PULSE = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] L_WAIT  = CW'(T_WAIT - 1);
   localparam logic [CW-1:0] L_CLEAR = CW'(T_CLEAR - 1);

   localparam logic [1:0] S_POWER   = 2'd0;
   localparam logic [1:0] S_INIT    = 2'd1;
   localparam logic [1:0] S_IDLE    = 2'd2;
   localparam logic [1:0] S_REFRESH = 2'd3;

   localparam logic [1:0] PH_SETUP  = 2'd0;
   localparam logic [1:0] PH_PULSE  = 2'd1;
   localparam logic [1:0] PH_SETTLE = 2'd2;

   logic [1:0]    state;
   logic [1:0]    phase;
   logic [CW-1:0] cnt;
   logic [5:0]    idx;
   logic [5:0]    nidx;
   logic [127:0]  snap1;
   logic [127:0]  snap2;
   logic [127:0]  row_sel;
   logic [3:0]    col;
   logic          pending;
   logic          req;
   logic          last_byte;
   logic          nxt_rs;
   logic [7:0]    nxt_data;

   assign lcd_rw = 1'b0;

`ifdef LCD_AUTO_REFRESH_EN
   logic diff_q;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) diff_q <= 1'b0;
      else       diff_q <= ({row1, row2} != {snap1, snap2});
   end

   assign req = update | pending | diff_q;
`else
   assign req = update | pending;
`endif

   assign last_byte = (state == S_INIT) ? (idx == 6'd3) : (idx == 6'd33);

   // Byte that follows the current one, always taken from the snapshot.
   always_comb begin
      nidx     = idx + 6'd1;
      col      = 4'd0;
      row_sel  = snap1;
      nxt_rs   = 1'b0;
      nxt_data = 8'h00;
      if (state == S_INIT) begin
         case (nidx[1:0])
            2'd1:    nxt_data = 8'h0C;
            2'd2:    nxt_data = 8'h06;
            2'd3:    nxt_data = 8'h01;
            default: nxt_data = 8'h38;
         endcase
      end else if (nidx == 6'd17) begin
         nxt_data = 8'hC0;
      end else begin
         nxt_rs = 1'b1;
         if (nidx < 6'd17) begin
            col     = 4'(nidx - 6'd1);
            row_sel = snap1;
         end else begin
            col     = 4'(nidx - 6'd18);
            row_sel = snap2;
         end
         nxt_data = row_sel[{~col, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state     <= S_POWER;
         phase     <= PH_SETUP;
         cnt       <= L_POWER;
         idx       <= 6'd0;
         snap1     <= '0;
         snap2     <= '0;
         pending   <= 1'b0;
         busy      <= 1'b1;
         init_done <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
      end else begin
         if (busy && update) pending <= 1'b1;
         case (state)
            S_POWER: begin
               if (cnt == '0) begin
                  state    <= S_INIT;
                  phase    <= PH_SETUP;
                  cnt      <= L_SETUP;
                  idx      <= 6'd0;
                  lcd_rs   <= 1'b0;
                  lcd_data <= 8'h38;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_IDLE: begin
               if (req) begin
                  snap1    <= row1;
                  snap2    <= row2;
                  pending  <= 1'b0;
                  state    <= S_REFRESH;
                  busy     <= 1'b1;
                  phase    <= PH_SETUP;
                  cnt      <= L_SETUP;
                  idx      <= 6'd0;
                  lcd_rs   <= 1'b0;
                  lcd_data <= 8'h80;
               end
            end
            default: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  case (phase)
                     PH_SETUP: begin
                        phase  <= PH_PULSE;
                        cnt    <= L_PULSE;
                        lcd_en <= 1'b1;
                     end
                     PH_PULSE: begin
                        phase  <= PH_SETTLE;
                        lcd_en <= 1'b0;
                        // Only the clear command (rs=0, 0x01) needs the long settle.
                        cnt    <= (!lcd_rs && lcd_data == 8'h01) ? L_CLEAR : L_WAIT;
                     end
                     default: begin
                        if (last_byte) begin
                           state <= S_IDLE;
                           busy  <= 1'b0;
                           if (state == S_INIT) init_done <= 1'b1;
                        end else begin
                           idx      <= nidx;
                           phase    <= PH_SETUP;
                           cnt      <= L_SETUP;
                           lcd_rs   <= nxt_rs;
                           lcd_data <= nxt_data;
                        end
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl; a negedge monitor logs every enable pulse as {rs, data, width}.
module tb_lcd_refresh_ctrl;

   logic         clk = 1'b0;
   logic         nRst = 1'b0;
   logic         update = 1'b0;
   logic [127:0] row1 = '0;
   logic [127:0] row2 = '0;
   logic         busy, init_done, lcd_en, lcd_rs, lcd_rw;
   logic [7:0]   lcd_data;

   lcd_refresh_ctrl #(
      .T_POWER(20), .T_SETUP(1), .T_PULSE(2), .T_WAIT(3), .T_CLEAR(8)
   ) dut (
      .clk(clk), .nRst(nRst), .row1(row1), .row2(row2), .update(update),
      .busy(busy), .init_done(init_done), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_data(lcd_data)
   );

   always #5 clk = ~clk;

   typedef struct { logic [127:0] r1; logic [127:0] r2; int exp_busy; } vec_t;
   typedef struct { logic rs; logic [7:0] d; int w; logic stable; } cap_t;

   logic [127:0] HANG1 = "  HANGMAN GAME  ";
   logic [127:0] HANG2 = "   __________   ";

   int n_checks = 0;
   int n_fail   = 0;

   cap_t       q[$];
   logic       prev_en = 1'b0;
   logic       prev_busy = 1'b1;
   int         en_run = 0;
   int         busy_run = 0;
   int         last_busy_len = 0;
   logic       cap_rs;
   logic [7:0] cap_d;
   logic       stab;

   always @(negedge clk) begin
      if (!nRst) begin
         en_run = 0; busy_run = 0; prev_en = 1'b0; prev_busy = 1'b1;
      end else begin
         if (lcd_en && !prev_en) begin
            cap_rs = lcd_rs; cap_d = lcd_data; stab = 1'b1; en_run = 0;
         end
         if (lcd_en) begin
            en_run++;
            if (lcd_rs !== cap_rs || lcd_data !== cap_d) stab = 1'b0;
         end
         if (!lcd_en && prev_en)
            q.push_back('{cap_rs, cap_d, en_run, stab && lcd_rs === cap_rs && lcd_data === cap_d});
         if (busy) busy_run++;
         if (!busy && prev_busy) begin
            last_busy_len = busy_run; busy_run = 0;
         end
         prev_en = lcd_en; prev_busy = busy;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] model_byte(input int i, input logic [127:0] r1, input logic [127:0] r2);
      if (i == 0)  return {1'b0, 8'h80};
      if (i <= 16) return {1'b1, r1[127-8*(i-1) -: 8]};
      if (i == 17) return {1'b0, 8'hC0};
      return {1'b1, r2[127-8*(i-18) -: 8]};
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 2000) begin tick(); n++; end
      if (busy) chk({name, "_idle_timeout"}, 1, 0);
   endtask

   task automatic wait_bytes(input int n, input string name);
      int k = 0;
      while (q.size() < n && k < 2000) begin tick(); k++; end
      if (q.size() < n) chk({name, "_bytes_timeout"}, q.size(), n);
   endtask

   task automatic check_refresh(input string tag, input int base, input logic [127:0] r1, input logic [127:0] r2);
      chk({tag, "_count"}, (q.size() >= base + 34) ? 1 : 0, 1);
      for (int i = 0; i < 34; i++) begin
         if (base + i < q.size()) begin
            chk($sformatf("%s_b%0d_rsdata", tag, i), {q[base+i].rs, q[base+i].d}, model_byte(i, r1, r2));
            chk($sformatf("%s_b%0d_width", tag, i), q[base+i].w, 2);
            chk($sformatf("%s_b%0d_stable", tag, i), q[base+i].stable, 1);
         end
      end
   endtask

   task automatic start_refresh(input logic [127:0] r1, input logic [127:0] r2);
      q.delete();
      row1 = r1; row2 = r2; update = 1'b1;
      tick();
      update = 1'b0;
   endtask

   task automatic do_init(input string tag);
      int n = 0;
      logic pid = 1'b1;
      logic [7:0] ib [4];
      ib = '{8'h38, 8'h0C, 8'h06, 8'h01};
      nRst = 1'b0; row1 = '0; row2 = '0; update = 1'b0;
      tick();
      q.delete();
      chk({tag, "_rst_en"}, lcd_en, 0);
      chk({tag, "_rst_rs"}, lcd_rs, 0);
      chk({tag, "_rst_rw"}, lcd_rw, 0);
      chk({tag, "_rst_data"}, lcd_data, 8'h00);
      chk({tag, "_rst_busy"}, busy, 1);
      chk({tag, "_rst_init_done"}, init_done, 0);
      nRst = 1'b1;
      while (busy && n < 200) begin pid = init_done; tick(); n++; end
      chk({tag, "_init_cycles"}, n, 49);
      chk({tag, "_init_done_high"}, init_done, 1);
      chk({tag, "_init_done_before"}, pid, 0);
      chk({tag, "_init_nbytes"}, q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < q.size()) begin
            chk($sformatf("%s_init_b%0d", tag, i), {q[i].rs, q[i].d}, {1'b0, ib[i]});
            chk($sformatf("%s_init_w%0d", tag, i), q[i].w, 2);
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [3];
      int n;
      vecs[0] = '{HANG1, HANG2, 204};
      vecs[1] = '{"0123456789ABCDEF", "fedcba9876543210", 204};
      vecs[2] = '{128'h01FF_0080_C038_0C06_7F20_2020_2020_0001,
                  128'h0101_0101_0101_0101_0101_0101_0101_0101, 204};

      do_init("por");

      for (int v = 0; v < 3; v++) begin
         start_refresh(vecs[v].r1, vecs[v].r2);
         chk($sformatf("v%0d_busy_start", v), busy, 1);
         chk($sformatf("v%0d_en_setup", v), lcd_en, 0);
         tick();
         chk($sformatf("v%0d_en_rise", v), lcd_en, 1);
         wait_idle($sformatf("v%0d", v));
         chk($sformatf("v%0d_busy_len", v), last_busy_len, vecs[v].exp_busy);
         check_refresh($sformatf("v%0d", v), 0, vecs[v].r1, vecs[v].r2);
         tick();
         chk($sformatf("v%0d_idle_en", v), lcd_en, 0);
         chk($sformatf("v%0d_idle_hold", v), {lcd_rs, lcd_data}, {1'b1, vecs[v].r2[7:0]});
         chk($sformatf("v%0d_rw", v), lcd_rw, 0);
      end

      // Row change mid-refresh must not leak into the running refresh.
      start_refresh(HANG1, HANG2);
      wait_bytes(5, "A");
      row1 = {16{8'h41}};
      wait_idle("A");
      check_refresh("A", 0, HANG1, HANG2);
`ifndef LCD_AUTO_REFRESH_EN
      repeat (300) tick();
      chk("A_no_second_refresh", q.size(), 34);
`else
      n = 0;
      while (!busy && n < 5) begin tick(); n++; end
      wait_idle("A_auto");
      chk("A_auto_second_refresh", q.size(), 68);
`endif

      // Three requests during a refresh collapse into one follow-up.
      start_refresh(HANG1, HANG2);
      wait_bytes(3, "B");
      repeat (3) begin
         update = 1'b1; tick(); update = 1'b0;
         repeat (4) tick();
      end
      wait_idle("B");
      chk("B_busy_gap", busy, 0);
      tick();
      chk("B_restart", busy, 1);
      wait_idle("B2");
      chk("B2_busy_len", last_busy_len, 204);
      repeat (300) tick();
      chk("B_total_bytes", q.size(), 68);
      check_refresh("B2", 34, HANG1, HANG2);

      // Update in the very cycle the refresh finishes becomes pending.
      start_refresh(vecs[1].r1, vecs[1].r2);
      wait_bytes(34, "C");
      tick();
      tick();
      update = 1'b1;
      tick();
      update = 1'b0;
      chk("C_busy_low", busy, 0);
      tick();
      chk("C_pending_restart", busy, 1);
      wait_idle("C2");
      chk("C_total_bytes", q.size(), 68);

      // Reset while enable is high.
      start_refresh(HANG1, HANG2);
      wait_bytes(6, "D");
      n = 0;
      while (!lcd_en && n < 50) begin tick(); n++; end
      chk("D_en_before_reset", lcd_en, 1);
      nRst = 1'b0;
      #1;
      chk("D_en_async", lcd_en, 0);
      chk("D_busy_async", busy, 1);
      chk("D_init_done_async", init_done, 0);
      chk("D_data_async", lcd_data, 8'h00);
      do_init("mid");

`ifdef LCD_AUTO_REFRESH_EN
      start_refresh(HANG1, HANG2);
      wait_idle("E0");
      q.delete();
      row2[7:0] = 8'h5F;
      n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      chk("E_auto_latency", (busy && n <= 2) ? 1 : 0, 1);
      wait_idle("E");
      chk("E_nbytes", q.size(), 34);
      if (q.size() == 34) chk("E_byte34", {q[33].rs, q[33].d}, {1'b1, 8'h5F});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
